// File: rtl/compare_serial_n_if.sv
// Handshake and operand bundle for the serial magnitude comparator.
// The master side issues compares and the slave side (the comparator) returns status and result flags.
interface compare_serial_n_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_greater_b;
  logic             a_equal_b;
  logic             a_less_b;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, a_greater_b, a_equal_b, a_less_b
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, a_greater_b, a_equal_b, a_less_b
  );
endinterface

// File: rtl/compare_serial_n.sv
// Multi-cycle magnitude comparator that scans CHUNK bits per cycle from the MSB end.
// It stops at the first differing chunk and supports unsigned or two's-complement compares.
module compare_serial_n #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  compare_serial_n_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Flipping the sign bit maps two's-complement onto offset binary, so one unsigned datapath serves both modes.
  function automatic logic [WIDTH-1:0] bias_operand(input logic [WIDTH-1:0] v, input logic sm);
    logic [WIDTH-1:0] r;
    r = v;
    r[WIDTH-1] = v[WIDTH-1] ^ sm;
    return r;
  endfunction

  state_t           state_r, state_n;
  logic [KW-1:0]    k_r, k_n;
  logic [WIDTH-1:0] a_r, a_n, b_r, b_n;
  logic             gt_r, gt_n, eq_r, eq_n, lt_r, lt_n;
  logic             busy_r, done_r;
  logic [CHUNK-1:0] chunk_a_s, chunk_b_s;

  // Next-state, chunk index, operand capture and result flag logic.
  always_comb begin
    state_n   = state_r;
    k_n       = k_r;
    a_n       = a_r;
    b_n       = b_r;
    gt_n      = gt_r;
    eq_n      = eq_r;
    lt_n      = lt_r;
    chunk_a_s = a_r[k_r*CHUNK +: CHUNK];
    chunk_b_s = b_r[k_r*CHUNK +: CHUNK];
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = SCAN;
          k_n     = K_TOP;
          a_n     = bias_operand(bus.a, bus.signed_mode);
          b_n     = bias_operand(bus.b, bus.signed_mode);
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (chunk_a_s != chunk_b_s) begin
          gt_n    = (chunk_a_s > chunk_b_s);
          lt_n    = (chunk_a_s < chunk_b_s);
          state_n = DONE;
        end else if (k_r == {KW{1'b0}}) begin
          eq_n    = 1'b1;
          state_n = DONE;
        end else begin
          k_n     = k_r - {{(KW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done are registered from the next state so outputs stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= {KW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
      a_r     <= a_n;
      b_r     <= b_n;
      gt_r    <= gt_n;
      eq_r    <= eq_n;
      lt_r    <= lt_n;
      busy_r  <= (state_n == SCAN);
      done_r  <= (state_n == DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.a_greater_b = gt_r;
  assign bus.a_equal_b   = eq_r;
  assign bus.a_less_b    = lt_r;
endmodule

// File: doc/compare_serial_n.md
Name:
compare_serial_n

Overview:
- Parametrised, multi-cycle magnitude comparator; next generation of the team's fixed 4-bit cascaded comparator.
- Scans two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk.
- Supports unsigned or two's-complement signed comparison, selected per operation.
- Uses a start/busy/done handshake and sits beside datapath blocks that need wide compares without a deep combinational chain.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK, minimum 2.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, maximum number of scan cycles.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; accepted only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; result flags are valid from this cycle.
- a_greater_b  output  1  A > B.
- a_equal_b  output  1  A == B.
- a_less_b  output  1  A < B.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; busy, done, a_greater_b, a_equal_b and a_less_b all 0; chunk index cleared. Reset overrides start and any scan in progress.
- States:
  - IDLE: busy=0.
  - SCAN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- Accept: start=1 while busy=0 (in IDLE or DONE).
  - Registers a, b and signed_mode.
  - Clears all three result flags.
  - Sets chunk index k=NCHUNK-1.
  - Next state is SCAN.
- start while busy=1 is ignored, with no side effects.
- Back-to-back: a start in the DONE cycle is accepted; the flags clear on the following edge.
- Signed mode: the operand MSBs are inverted before comparing (offset-binary), so one unsigned chunk datapath serves both modes.
- Each SCAN cycle compares chunk k (bits [k*CHUNK+CHUNK-1 : k*CHUNK]) of the registered operands.
  - Chunks differ: set a_greater_b or a_less_b from that chunk, then go to DONE.
  - Chunks equal and k=0: set a_equal_b=1, then go to DONE.
  - Chunks equal and k>0: k <= k-1, stay in SCAN.
- Latency from the accept edge to the done-high cycle is j edges, where j is the 1-based position of the first differing chunk counted from the MSB.
  - Equal operands take NCHUNK edges.
  - The minimum is 1 edge and the maximum is NCHUNK.
- Exactly one result flag is 1 after done.
- The flags hold their value until the next accepted start or reset.
- done=1 only in the DONE state and never coincides with busy=1.
- Input changes on a, b and signed_mode after the accept have no effect on the current operation.
- CHUNK=WIDTH is legal: always 1 cycle. CHUNK=1 is legal: up to WIDTH cycles.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Defaults WIDTH=16, CHUNK=4. Hold rst_n=0 for 2 edges with start=1, a=0xFFFF, b=0 -> busy, done and all flags are 0; no operation starts after release until start is reasserted.
- Unsigned, a=0x1234, b=0x1234, start for one cycle -> busy=1 for 4 cycles, done pulses at accept+4, a_equal_b=1, others 0, flags held for 10 further idle cycles.
- Unsigned, a=0x8000, b=0x7FFF -> done at accept+1, a_greater_b=1. Same operands with signed_mode=1 -> done at accept+1, a_less_b=1 (-32768 < 32767).
- Unsigned, a=0x12A4, b=0x12B4 -> done at accept+3, a_less_b=1. Signed, a=0xFFFE, b=0xFFFF -> done at accept+4, a_less_b=1.
- Start pulsed again at accept+1 with a=0, b=1 during an equal-operand scan -> ignored; the original result (a_equal_b) is reported at accept+4. Start asserted in the DONE cycle -> accepted, and the flags read 0 on the next cycle.
- rst_n=0 at accept+2 of a 4-chunk scan -> next cycle busy=0, done=0, flags 0; done never pulses for the aborted operation. A new start is accepted normally afterwards.
